// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: pipeline status inputs, per-register write/flush controls, counters.
interface pipeline_hazard_controller_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 ID_EX_MemRead;
  logic [4:0]           ID_EX_RegisterRd;
  logic [4:0]           IF_ID_RegisterRs1;
  logic [4:0]           IF_ID_RegisterRs2;
  logic                 ID_EX_MultiCycle;
  logic                 EX_BranchTaken;
  logic                 MEM_Req;
  logic                 dmem_ready;
  logic                 PC_Write;
  logic                 IF_ID_Write;
  logic                 ID_EX_Write;
  logic                 EX_MEM_Write;
  logic                 MEM_WB_Write;
  logic                 IF_ID_Flush;
  logic                 ID_EX_Flush;
  logic                 EX_MEM_Flush;
  logic [1:0]           ctrl_state;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  // Pipeline side: reports stage status, receives controls.
  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_RegisterRs2,
    output ID_EX_MultiCycle, EX_BranchTaken, MEM_Req, dmem_ready,
    input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
    input  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
    input  ctrl_state, stall_count, flush_count
  );

  // Controller side.
  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_RegisterRs2,
    input  ID_EX_MultiCycle, EX_BranchTaken, MEM_Req, dmem_ready,
    output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
    output IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
    output ctrl_state, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, dmem wait freezes and fixed-latency multi-cycle EX holds, plus
// saturating stall/flush counters. Controls are combinational from state and inputs.
module pipeline_hazard_controller #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                          clk,
  input logic                          reset,
  pipeline_hazard_controller_if.slave  bus
);

  // Counter only needs to hold MC_LATENCY-2 (entry cycle in RUN plus the release cycle).
  localparam int unsigned MC_W    = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LATENCY - 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MC_WAIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [MC_W-1:0]      mc_q, mc_d;
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  logic load_use_c, mem_stall_c;
  logic pc_write_c, if_id_write_c, id_ex_write_c, ex_mem_write_c, mem_wb_write_c;
  logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;

  // Hazard detection; x0 is never a real dependency.
  assign load_use_c  = bus.ID_EX_MemRead && (bus.ID_EX_RegisterRd != 5'd0) &&
                       ((bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRs1) ||
                        (bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRs2));
  assign mem_stall_c = bus.MEM_Req && !bus.dmem_ready;

  // State and multi-cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
    end
  end

  // Next state and pipeline controls; priority: mem stall, multi-cycle, branch, load-use.
  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    id_ex_write_c  = 1'b1;
    ex_mem_write_c = 1'b1;
    mem_wb_write_c = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    state_d        = state_q;
    mc_d           = mc_q;

    case (state_q)
      RUN, MEM_WAIT: begin
        // In MEM_WAIT only dmem_ready matters; its release cycle follows the RUN rules.
        if ((state_q == RUN) ? mem_stall_c : !bus.dmem_ready) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_write_c  = 1'b0;
          ex_mem_write_c = 1'b0;
          mem_wb_write_c = 1'b0;
          state_d        = MEM_WAIT;
        end else begin
          state_d = RUN;
          if (bus.ID_EX_MultiCycle) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_write_c  = 1'b0;
            ex_mem_flush_c = 1'b1;
            mc_d           = MC_LOAD;
            state_d        = MC_WAIT;
          end else if (bus.EX_BranchTaken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (load_use_c) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
          end
        end
      end
      MC_WAIT: begin
        // MEM only holds bubbles here, so dmem handshakes are ignored.
        if (mc_q != '0) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_write_c  = 1'b0;
          ex_mem_flush_c = 1'b1;
          mc_d           = mc_q - MC_W'(1);
        end else begin
          state_d = RUN;
          if (bus.EX_BranchTaken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    // Reset freezes every pipeline register and suppresses flushes.
    if (reset) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_write_c  = 1'b0;
      ex_mem_write_c = 1'b0;
      mem_wb_write_c = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_flush_c  = 1'b0;
      ex_mem_flush_c = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write_c && (stall_q != '1)) stall_q <= stall_q + CNT_WIDTH'(1);
      if (if_id_flush_c && (flush_q != '1)) flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end

  assign bus.PC_Write     = pc_write_c;
  assign bus.IF_ID_Write  = if_id_write_c;
  assign bus.ID_EX_Write  = id_ex_write_c;
  assign bus.EX_MEM_Write = ex_mem_write_c;
  assign bus.MEM_WB_Write = mem_wb_write_c;
  assign bus.IF_ID_Flush  = if_id_flush_c;
  assign bus.ID_EX_Flush  = id_ex_flush_c;
  assign bus.EX_MEM_Flush = ex_mem_flush_c;
  assign bus.ctrl_state   = state_q;
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: per-cycle stimulus with expected
// controls/state/counters queued at drive time and compared mid-cycle.
module tb_pipeline_hazard_controller;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID, ID_EX, EX_MEM flushes}
  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_FRZ = 8'b00000_000;
  localparam logic [7:0] C_LU  = 8'b00111_010;
  localparam logic [7:0] C_BR  = 8'b11111_110;
  localparam logic [7:0] C_MC  = 8'b00011_001;

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mc;
    logic       br;
    logic       mq;
    logic       dr;
  } stim_t;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic clk;
  logic reset;
  logic reset2;
  int   total;
  int   bad;
  exp_t sb[$];
  logic [1:0] sb2[$];

  pipeline_hazard_controller_if #(.CNT_WIDTH(16)) bus ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(2))  bus2 ();

  pipeline_hazard_controller #(.MC_LATENCY(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pipeline_hazard_controller #(.MC_LATENCY(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(int mr, int rd, int rs1, int rs2, int mc, int br, int mq, int dr);
    return {1'(mr), 5'(rd), 5'(rs1), 5'(rs2), 1'(mc), 1'(br), 1'(mq), 1'(dr)};
  endfunction

  function automatic exp_t mke(logic [7:0] ctl, int st, int stall, int flush);
    return {ctl, 2'(st), 16'(stall), 16'(flush)};
  endfunction

  function automatic exp_t observe();
    return {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Write, bus.EX_MEM_Write,
            bus.MEM_WB_Write, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush,
            bus.ctrl_state, bus.stall_count, bus.flush_count};
  endfunction

  task automatic apply(stim_t s);
    bus.ID_EX_MemRead     = s.mr;
    bus.ID_EX_RegisterRd  = s.rd;
    bus.IF_ID_RegisterRs1 = s.rs1;
    bus.IF_ID_RegisterRs2 = s.rs2;
    bus.ID_EX_MultiCycle  = s.mc;
    bus.EX_BranchTaken    = s.br;
    bus.MEM_Req           = s.mq;
    bus.dmem_ready        = s.dr;
  endtask

  task automatic apply_sat(stim_t s);
    bus2.ID_EX_MemRead     = s.mr;
    bus2.ID_EX_RegisterRd  = s.rd;
    bus2.IF_ID_RegisterRs1 = s.rs1;
    bus2.IF_ID_RegisterRs2 = s.rs2;
    bus2.ID_EX_MultiCycle  = s.mc;
    bus2.EX_BranchTaken    = s.br;
    bus2.MEM_Req           = s.mq;
    bus2.dmem_ready        = s.dr;
  endtask

  task automatic do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t want, got;
    apply(mk(1, 5, 5, 0, 1, 1, 1, 0));
    sb.push_back(mke(C_FRZ, 0, 0, 0));
    @(negedge clk);
    want = sb.pop_front(); got = observe(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
               got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
    end
  endtask

  task automatic test_load_use();
    stim_t s[7]; exp_t e[7]; exp_t want, got;
    do_reset();
    s[0] = mk(1, 5, 5, 0, 0, 0, 0, 1); e[0] = mke(C_LU,  0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[1] = mke(C_RUN, 0, 1, 0);
    s[2] = mk(1, 5, 3, 5, 0, 0, 0, 1); e[2] = mke(C_LU,  0, 1, 0);
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[3] = mke(C_RUN, 0, 2, 0);
    s[4] = mk(1, 0, 0, 0, 0, 0, 0, 1); e[4] = mke(C_RUN, 0, 2, 0);
    s[5] = mk(0, 5, 5, 0, 0, 0, 0, 1); e[5] = mke(C_RUN, 0, 2, 0);
    s[6] = mk(1, 7, 5, 6, 0, 0, 0, 1); e[6] = mke(C_RUN, 0, 2, 0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      want = sb.pop_front(); got = observe(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL load_use[%0d] got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s[4]; exp_t e[4]; exp_t want, got;
    do_reset();
    s[0] = mk(1, 5, 5, 0, 0, 1, 0, 1); e[0] = mke(C_BR,  0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[1] = mke(C_RUN, 0, 0, 1);
    s[2] = mk(0, 0, 0, 0, 0, 1, 0, 1); e[2] = mke(C_BR,  0, 0, 1);
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[3] = mke(C_RUN, 0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      want = sb.pop_front(); got = observe(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL branch[%0d] got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[8]; exp_t e[8]; exp_t want, got;
    do_reset();
    s[0] = mk(0, 0, 0, 0, 0, 1, 1, 0); e[0] = mke(C_FRZ, 0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 0, 0, 1, 0); e[1] = mke(C_FRZ, 1, 1, 0);
    s[2] = mk(0, 0, 0, 0, 0, 0, 1, 0); e[2] = mke(C_FRZ, 1, 2, 0);
    s[3] = mk(0, 0, 0, 0, 0, 0, 1, 1); e[3] = mke(C_RUN, 1, 3, 0);
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[4] = mke(C_RUN, 0, 3, 0);
    s[5] = mk(0, 0, 0, 0, 0, 0, 1, 0); e[5] = mke(C_FRZ, 0, 3, 0);
    s[6] = mk(1, 5, 5, 0, 0, 1, 1, 1); e[6] = mke(C_BR,  1, 4, 0);
    s[7] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[7] = mke(C_RUN, 0, 4, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      want = sb.pop_front(); got = observe(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL mem_wait[%0d] got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
      end
    end
  endtask

  task automatic test_multicycle();
    stim_t s[5]; exp_t e[5]; exp_t want, got;
    do_reset();
    s[0] = mk(0, 0, 0, 0, 1, 0, 0, 1); e[0] = mke(C_MC,  0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 1, 0, 1, 0); e[1] = mke(C_MC,  2, 1, 0);
    s[2] = mk(0, 0, 0, 0, 1, 0, 0, 1); e[2] = mke(C_MC,  2, 2, 0);
    s[3] = mk(0, 0, 0, 0, 1, 1, 0, 1); e[3] = mke(C_BR,  2, 3, 0);
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[4] = mke(C_RUN, 0, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      want = sb.pop_front(); got = observe(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL multicycle[%0d] got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[7]; exp_t e[7]; exp_t want, got;
    do_reset();
    s[0] = mk(0, 0, 0, 0, 0, 0, 1, 0); e[0] = mke(C_FRZ, 0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 1, 0, 1, 1); e[1] = mke(C_MC,  1, 1, 0);
    s[2] = mk(0, 0, 0, 0, 1, 0, 0, 1); e[2] = mke(C_MC,  2, 2, 0);
    s[3] = mk(0, 0, 0, 0, 1, 0, 0, 1); e[3] = mke(C_MC,  2, 3, 0);
    s[4] = mk(0, 0, 0, 0, 1, 0, 0, 1); e[4] = mke(C_RUN, 2, 4, 0);
    s[5] = mk(1, 5, 5, 0, 0, 0, 0, 1); e[5] = mke(C_LU,  0, 4, 0);
    s[6] = mk(0, 0, 0, 0, 0, 0, 0, 1); e[6] = mke(C_RUN, 0, 5, 0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      want = sb.pop_front(); got = observe(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back[%0d] got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
      end
    end
  endtask

  task automatic test_reset_mc();
    stim_t s[2]; exp_t e[2]; exp_t want, got;
    do_reset();
    s[0] = mk(0, 0, 0, 0, 1, 0, 0, 1); e[0] = mke(C_MC, 0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 1, 0, 0, 1); e[1] = mke(C_MC, 2, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
      @(negedge clk);
      want = sb.pop_front(); got = observe(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mc[%0d] got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
                 i, got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
      end
    end
    // Second MC_WAIT cycle: assert reset mid-cycle, away from any edge.
    @(posedge clk); #1; apply(s[1]);
    #1; reset = 1'b1; sb.push_back(mke(C_FRZ, 0, 0, 0));
    #1;
    want = sb.pop_front(); got = observe(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_async got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
               got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1; sb.push_back(mke(C_RUN, 0, 0, 0));
    @(negedge clk);
    want = sb.pop_front(); got = observe(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_release got ctl=%b st=%0d stall=%0d flush=%0d want ctl=%b st=%0d stall=%0d flush=%0d",
               got.ctl, got.st, got.stall, got.flush, want.ctl, want.st, want.stall, want.flush);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    apply_sat(mk(0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk); reset2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply_sat(mk(1, 5, 5, 0, 0, 0, 0, 1));
      @(posedge clk); #1; apply_sat(mk(0, 0, 0, 0, 0, 0, 0, 1));
      sb2.push_back(2'((i + 1 > 3) ? 3 : i + 1));
      @(negedge clk);
      want = sb2.pop_front(); total++;
      if (bus2.stall_count !== want) begin
        bad++;
        $display("FAIL sat_stall[%0d] got %0d want %0d", i, bus2.stall_count, want);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply_sat(mk(0, 0, 0, 0, 0, 1, 0, 1));
      @(posedge clk); #1; apply_sat(mk(0, 0, 0, 0, 0, 0, 0, 1));
      sb2.push_back(2'((i + 1 > 3) ? 3 : i + 1));
      @(negedge clk);
      want = sb2.pop_front(); total++;
      if (bus2.flush_count !== want) begin
        bad++;
        $display("FAIL sat_flush[%0d] got %0d want %0d", i, bus2.flush_count, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk    = 1'b0;
    reset  = 1'b1;
    reset2 = 1'b1;
    total  = 0;
    bad    = 0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1));
    apply_sat(mk(0, 0, 0, 0, 0, 0, 0, 1));
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_multicycle();
    test_back_to_back();
    test_reset_mc();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Combines four conditions into per-register write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - load-use data hazards,
  - taken branches/jumps resolved in EX,
  - variable-latency data-memory accesses,
  - fixed-latency multi-cycle EX operations (mul/div).
- Also keeps saturating stall and flush performance counters.

Parameters:
- MC_LATENCY, 4: total EX occupancy in cycles of a multi-cycle op; legal range ≥2.
- CNT_WIDTH, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_RegisterRd  in  5  destination register of the EX instruction.
- IF_ID_RegisterRs1  in  5  rs1 of the ID instruction.
- IF_ID_RegisterRs2  in  5  rs2 of the ID instruction.
- ID_EX_MultiCycle  in  1  the EX instruction is a multi-cycle op.
- EX_BranchTaken  in  1  branch/jump in EX resolved taken.
- MEM_Req  in  1  the MEM-stage instruction accesses dmem.
- dmem_ready  in  1  dmem completes its access this cycle.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- ID_EX_Write  out  1  ID/EX load enable.
- EX_MEM_Write  out  1  EX/MEM load enable.
- MEM_WB_Write  out  1  MEM/WB load enable.
- IF_ID_Flush  out  1  load a NOP into IF/ID.
- ID_EX_Flush  out  1  load a bubble into ID/EX (control bits zeroed).
- EX_MEM_Flush  out  1  load a bubble into EX/MEM.
- ctrl_state  out  2  current state: 0=RUN, 1=MEM_WAIT, 2=MC_WAIT.
- stall_count  out  CNT_WIDTH  count of cycles with PC_Write=0.
- flush_count  out  CNT_WIDTH  count of cycles with IF_ID_Flush=1.

Behaviour:
- Reset (asynchronous), while reset=1:
  - State goes to RUN, the MC counter clears, and both performance counters clear to 0.
  - All *_Write outputs are forced to 0 and all *_Flush outputs to 0.
  - An assertion in any state, including mid MEM_WAIT or MC_WAIT, aborts the wait immediately.
- Outputs are combinational from state and inputs. Defaults: every *_Write=1, every *_Flush=0.
- load_use = ID_EX_MemRead & (ID_EX_RegisterRd≠0) & (Rd==Rs1 | Rd==Rs2). x0 never stalls.
- RUN state, conditions evaluated in this priority order:
  1. mem_stall = MEM_Req & ~dmem_ready.
     - All five *_Write=0, no flushes.
     - Next state MEM_WAIT.
  2. ID_EX_MultiCycle.
     - PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Flush=1; MEM/WB flows.
     - MC counter loads MC_LATENCY-2; next state MC_WAIT.
  3. EX_BranchTaken.
     - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 (target loads).
     - load_use is ignored.
  4. load_use.
     - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
     - Single-cycle bubble; no state change.
- MEM_WAIT state:
  - While dmem_ready=0: all *_Write=0, no flushes.
  - On dmem_ready=1 (release cycle): apply the RUN rules with mem_stall treated as false. This cycle may itself enter MC_WAIT, flush or bubble. Next state is RUN unless MC_WAIT is entered.
- MC_WAIT state:
  - MEM_Req is ignored; only bubbles occupy MEM.
  - While counter≠0: same controls as the RUN multi-cycle case (without reloading the counter); counter decrements.
  - When counter==0 (release cycle): all writes 1; EX_BranchTaken is honoured as in RUN; next state RUN. load_use cannot occur because the EX op is not a load.
  - Total EX occupancy is exactly MC_LATENCY cycles, counting the entry cycle in RUN.
- Counters:
  - Each increments by 1 on an edge where its condition held during the preceding cycle.
  - Each saturates at 2^CNT_WIDTH-1 and does not wrap.
- Simultaneous events:
  - mem_stall dominates everything.
  - A branch and a load-use in the same cycle produce a flush only: stall_count unchanged, flush_count +1.

Test Plan:
- Load-use: MemRead=1, Rd=5, Rs1=5 in RUN → exactly one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_count=1.
- x0 case: MemRead=1, Rd=0, Rs1=0 → no stall; all writes 1.
- Branch and load-use together: EX_BranchTaken=1 with a matching load_use → IF_ID_Flush=ID_EX_Flush=1, PC_Write=1; flush_count=1, stall_count=0.
- Memory wait: MEM_Req=1 with dmem_ready low for 3 cycles, then high → 3 frozen cycles (all writes 0) in states RUN, MEM_WAIT, MEM_WAIT; release on cycle 4; ctrl_state returns to 0; stall_count=3.
- Multi-cycle op: MC_LATENCY=4, MultiCycle=1 → 3 cycles with PC_Write=0 and EX_MEM_Flush=1, 4th cycle releases; stall_count=3.
- Reset during MC_WAIT plus saturation:
  - Assert reset in the 2nd MC_WAIT cycle → ctrl_state=0 and counters 0 asynchronously.
  - With CNT_WIDTH=2 and 5 load-use stalls → stall_count holds at 3.
